memory_bank: RTL and testbench

MEMORY_BANK -- requirements
Module: memory_bank

---
 rtl/memory_pkg.sv | 12 +
 rtl/mem_array.sv | 33 +++
 rtl/memory_bank.sv | 137 +++++++++++++
 tb/tb_memory_bank.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for memory_bank: FSM encodings and the legal read-latency range.
package memory_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/mem_array.sv
// Single-port-write / single-port-read storage with byte enables and a registered,
// read-before-write output; collision handling is done by the caller.
module mem_array #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AWIDTH-1:0]   wr_addr,
  input  logic [DWIDTH-1:0]   wr_data,
  input  logic [DWIDTH/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [AWIDTH-1:0]   rd_addr,
  output logic [DWIDTH-1:0]   rd_data
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int NB    = DWIDTH / 8;

  logic [DWIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch so it maps onto RAM primitives; the
  // owner's clear sequence zeroes it instead.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/memory_bank.sv
// Byte-enabled memory bank: power-on clear FSM, write-first collision merge and a
// 1- or 2-cycle read pipeline around mem_array.
module memory_bank
  import memory_pkg::*;
#(
  parameter int AWIDTH     = 5,
  parameter int DWIDTH     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AWIDTH-1:0]   wr_addr,
  input  logic [DWIDTH-1:0]   wr_data,
  input  logic [DWIDTH/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [AWIDTH-1:0]   rd_addr,
  output logic [DWIDTH-1:0]   rd_data,
  output logic                rd_valid,
  output logic                busy
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam int NB    = DWIDTH / 8;

  if ((DWIDTH % 8) != 0 || RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_param
    $error("memory_bank: DWIDTH must be a multiple of 8 and RD_LATENCY must be 1 or 2");
  end

  state_t            state, state_next;
  logic [AWIDTH:0]   cnt, cnt_next;

  // NOTE: state registers use non-blocking assignments; the combinational
  // next-state block below uses blocking ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (state == ST_INIT) begin
      cnt_next = cnt + (AWIDTH + 1)'(1);
      if (cnt == (AWIDTH + 1)'(DEPTH - 1)) state_next = ST_READY;
    end
  end

  assign busy = (state == ST_INIT);

  logic acc_rd, acc_wr;
  assign acc_rd = rd_en & ~busy & ~rst;
  assign acc_wr = wr_en & ~busy & ~rst;

  // During the clear the write port is taken over by the counter.
  logic                arr_wr_en;
  logic [AWIDTH-1:0]   arr_wr_addr;
  logic [DWIDTH-1:0]   arr_wr_data;
  logic [NB-1:0]       arr_wr_be;
  logic [DWIDTH-1:0]   arr_rd_data;

  assign arr_wr_en   = busy | acc_wr;
  assign arr_wr_addr = busy ? cnt[AWIDTH-1:0] : wr_addr;
  assign arr_wr_data = busy ? '0 : wr_data;
  assign arr_wr_be   = busy ? '1 : wr_be;

  mem_array #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_mem_array (
    .clk     (clk),
    .wr_en   (arr_wr_en),
    .wr_addr (arr_wr_addr),
    .wr_data (arr_wr_data),
    .wr_be   (arr_wr_be),
    .rd_en   (acc_rd),
    .rd_addr (rd_addr),
    .rd_data (arr_rd_data)
  );

  // The array returns pre-write contents, so a same-address write is captured
  // here and overlaid on the enabled bytes to give write-first behaviour.
  logic              v1;
  logic              col_q;
  logic [DWIDTH-1:0] col_data_q;
  logic [NB-1:0]     col_be_q;
  logic [DWIDTH-1:0] merged;

  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else     v1 <= acc_rd;
    col_q      <= acc_rd & acc_wr & (wr_addr == rd_addr);
    col_data_q <= wr_data;
    col_be_q   <= wr_be;
  end

  always_comb begin
    merged = arr_rd_data;
    if (col_q) begin
      for (int i = 0; i < NB; i++) begin
        if (col_be_q[i]) merged[8*i +: 8] = col_data_q[8*i +: 8];
      end
    end
  end

  logic              out_v;
  logic [DWIDTH-1:0] out_d;

  if (RD_LATENCY == 2) begin : g_lat2
    logic              v2;
    logic [DWIDTH-1:0] d2;
    always_ff @(posedge clk) begin
      if (rst) v2 <= 1'b0;
      else     v2 <= v1;
      if (v1) d2 <= merged;
    end
    assign out_v = v2;
    assign out_d = d2;
  end else begin : g_lat1
    assign out_v = v1;
    assign out_d = merged;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= out_v;
      if (out_v) rd_data <= out_d;
    end
  end

endmodule

// File: tb/tb_memory_bank.sv
// Scoreboard bench: two banks (read latency 1 and 2) share stimulus; monitors
// check each returned word and its arrival cycle against queued expectations.
module tb_memory_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en;
  logic [4:0]  rd_addr;

  logic [15:0] rd_data1, rd_data2;
  logic        rd_valid1, rd_valid2, busy1, busy2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_bank #(.AWIDTH(5), .DWIDTH(16), .RD_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1)
  );

  memory_bank #(.AWIDTH(5), .DWIDTH(16), .RD_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: each valid pulse must match the oldest expectation in value and cycle.
  always @(negedge clk) begin
    if (rd_valid1) begin
      if (q1.size() == 0) check("l1_unexpected_valid", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("l1_data", 32'(rd_data1), 32'(e1.data));
        check("l1_latency", 32'(cyc), 32'(e1.due));
      end
    end
    if (rd_valid2) begin
      if (q2.size() == 0) check("l2_unexpected_valid", 32'd1, 32'd0);
      else begin
        e2 = q2.pop_front();
        check("l2_data", 32'(rd_data2), 32'(e2.data));
        check("l2_latency", 32'(cyc), 32'(e2.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; when push is set the read's result is queued for both banks.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                       input logic [1:0] be, input logic re, input logic [4:0] ra,
                       input logic push, input logic [15:0] exp);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = ra;
    if (push) begin
      q1.push_back('{data: exp, due: cyc + 2});
      q2.push_back('{data: exp, due: cyc + 3});
    end
    tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic [1:0] be);
    drive(1'b1, a, d, be, 1'b0, 5'd0, 1'b0, 16'h0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [15:0] exp);
    drive(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, a, 1'b1, exp);
  endtask

  task automatic idle(input int n);
    wr_en = 1'b0;
    rd_en = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      tick();
    end
    check(name, 32'(n), 32'd32);
    check({name, "_l2_done"}, 32'(busy2), 32'd0);
  endtask

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 257) ^ 16'hA55A;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;
    tick(); tick();
    check("rst_valid_l1", 32'(rd_valid1), 32'd0);
    check("rst_valid_l2", 32'(rd_valid2), 32'd0);
    check("rst_data_l1",  32'(rd_data1),  32'd0);
    check("rst_data_l2",  32'(rd_data2),  32'd0);
    check("rst_busy_l1",  32'(busy1),     32'd1);
    check("rst_busy_l2",  32'(busy2),     32'd1);

    // Clear sequence with rd_en held high: exactly 32 busy cycles, no valids.
    rst = 1'b0; rd_en = 1'b1; rd_addr = 5'd4;
    count_busy("clear_busy_cycles");
    for (int i = 0; i < 32; i++) rd(5'(i), 16'h0000);
    idle(4);

    // Byte-enable merging: 0xABCD (be=11), 0x1200 (be=10), then be=00 changes nothing.
    wr(5'd5, 16'hABCD, 2'b11);
    wr(5'd5, 16'h1200, 2'b10);
    wr(5'd5, 16'hFFFF, 2'b00);
    rd(5'd5, 16'h12CD);
    idle(3);

    // Same-address read/write is write-first, per byte.
    wr(5'd3, 16'h0011, 2'b11);
    drive(1'b1, 5'd3, 16'h005A, 2'b11, 1'b1, 5'd3, 1'b1, 16'h005A);
    drive(1'b1, 5'd3, 16'hBEEF, 2'b01, 1'b1, 5'd3, 1'b1, 16'h00EF);
    rd(5'd3, 16'h00EF);
    idle(3);

    // Different addresses in the same cycle proceed independently.
    drive(1'b1, 5'd9, 16'h7777, 2'b11, 1'b1, 5'd5, 1'b1, 16'h12CD);
    rd(5'd9, 16'h7777);
    idle(3);

    // A write one cycle after a read does not alter the launched result.
    wr(5'd7, 16'h1111, 2'b11);
    rd(5'd7, 16'h1111);
    wr(5'd7, 16'h2222, 2'b11);
    rd(5'd7, 16'h2222);
    idle(3);

    // Full sweep: fill with a pattern, then 32 back-to-back reads in address order.
    for (int i = 0; i < 32; i++) wr(5'(i), pat(i), 2'b11);
    for (int i = 0; i < 32; i++) rd(5'(i), pat(i));
    idle(4);

    // Reset one cycle after a read is issued: the read is discarded and rd_data clears.
    drive(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd9, 1'b0, 16'h0);
    rst = 1'b1; rd_en = 1'b0;
    tick();
    check("midread_valid_l1", 32'(rd_valid1), 32'd0);
    check("midread_valid_l2", 32'(rd_valid2), 32'd0);
    check("midread_data_l1",  32'(rd_data1),  32'd0);
    check("midread_data_l2",  32'(rd_data2),  32'd0);
    check("midread_busy_l1",  32'(busy1),     32'd1);

    // Reset again at clear cycle 10: the clear restarts from address 0.
    rst = 1'b0;
    idle(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy("restart_busy_cycles");
    check("restart_data_l1", 32'(rd_data1), 32'd0);
    check("restart_data_l2", 32'(rd_data2), 32'd0);
    rd(5'd9, 16'h0000);
    rd(5'd31, 16'h0000);
    idle(5);

    check("l1_drained", 32'(q1.size()), 32'd0);
    check("l2_drained", 32'(q2.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
